// File: rtl/lpif_pkg.sv
// -----------------------------------------------------------------------------
// lpif_pkg
// Shared definitions for the LPIF transmit path: beat geometry, the MAC state
// code for Active, the packer FSM states, the beat record and a saturating
// end-marker counter helper used by the optional statistics logic.
// -----------------------------------------------------------------------------
package lpif_pkg;

  localparam int         LPIF_BYTES = 64;             // bytes per LPIF beat
  localparam int         LPIF_DW    = LPIF_BYTES / 4; // dword slots per beat
  localparam logic [3:0] STS_ACTIVE = 4'h1;           // pl_state_sts == Active

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // buffer empty
    FILL = 2'd1,  // 1..15 slots used
    SEND = 2'd2   // beat presented to the MAC
  } lpif_tx_state_e;

  typedef struct packed {
    logic [8*LPIF_BYTES-1:0] data;
    logic [LPIF_BYTES-1:0]   valid;
    logic [LPIF_BYTES-1:0]   tlpstart;
    logic [LPIF_BYTES-1:0]   tlpend;
    logic [LPIF_BYTES-1:0]   dlpstart;
    logic [LPIF_BYTES-1:0]   dlpend;
  } lpif_beat_t;

  // Adds the number of set marker bits to a 16-bit counter, sticking at all-ones.
  function automatic logic [15:0] sat_add_cnt(input logic [15:0]           cnt,
                                              input logic [LPIF_BYTES-1:0] marks);
    logic [16:0] sum;
    sum = {1'b0, cnt};
    for (int i = 0; i < LPIF_BYTES; i++) begin
      sum = sum + {16'd0, marks[i]};
    end
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/lpif_tx_marker_gen.sv
// -----------------------------------------------------------------------------
// lpif_tx_marker_gen
// Turns one accepted dword (slot index, sop/eop, packet type) into the byte
// masks it contributes to an LPIF beat.
//   slot          : dword slot 0..15 within the beat
//   sop / eop     : dword starts / ends a packet
//   is_dlp        : packet type (DLP when 1, TLP when 0)
//   valid_mask    : 4 valid bytes for the slot
//   *start_mask   : byte 4*slot set on sop, in the vector chosen by is_dlp
//   *end_mask     : byte 4*slot+3 set on eop, in the vector chosen by is_dlp
// -----------------------------------------------------------------------------
module lpif_tx_marker_gen
  import lpif_pkg::*;
(
  input  logic [3:0]            slot,
  input  logic                  sop,
  input  logic                  eop,
  input  logic                  is_dlp,
  output logic [LPIF_BYTES-1:0] valid_mask,
  output logic [LPIF_BYTES-1:0] tlpstart_mask,
  output logic [LPIF_BYTES-1:0] tlpend_mask,
  output logic [LPIF_BYTES-1:0] dlpstart_mask,
  output logic [LPIF_BYTES-1:0] dlpend_mask
);

  logic [5:0] byte_idx;
  assign byte_idx = {slot, 2'b00};

  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no
    // path leaves a signal unassigned and no latch is inferred.
    valid_mask    = '0;
    tlpstart_mask = '0;
    tlpend_mask   = '0;
    dlpstart_mask = '0;
    dlpend_mask   = '0;
    valid_mask[byte_idx +: 4] = 4'hF;
    if (sop) begin
      if (is_dlp) dlpstart_mask[byte_idx] = 1'b1;
      else        tlpstart_mask[byte_idx] = 1'b1;
    end
    if (eop) begin
      if (is_dlp) dlpend_mask[byte_idx + 6'd3] = 1'b1;
      else        tlpend_mask[byte_idx + 6'd3] = 1'b1;
    end
  end

endmodule

// File: rtl/lpif_tx_packer.sv
// -----------------------------------------------------------------------------
// lpif_tx_packer
// Packs a dword-serial TLP/DLP stream into 512-bit LPIF beats with per-byte
// valid/start/end markers and presents them to the MAC under pl_trdy
// backpressure. Transmits only while the link is up and in Active.
//   LCLK, lpreset        : clock, async active-high reset
//   pl_linkUp/state_sts  : MAC link status; pl_trdy: MAC accepts the beat
//   s_valid/s_ready/...  : dword input (s_data, s_sop, s_eop, s_is_dlp)
//   lp_irdy, lp_data,... : registered beat and byte markers toward the MAC
//   pkt_dropped          : pulse when buffered data is discarded on link loss
//   proto_err            : pulse on sop inside a packet or non-sop while idle
// Optional build macro LPIF_TX_STATS_EN adds tlp_sent_cnt / dlp_sent_cnt,
// saturating counts of end markers in transferred beats.
// -----------------------------------------------------------------------------
module lpif_tx_packer
  import lpif_pkg::*;
#(
  parameter int         BEAT_BYTES = lpif_pkg::LPIF_BYTES,
  parameter logic [3:0] STS_ACTIVE = lpif_pkg::STS_ACTIVE
) (
  input  logic                    LCLK,
  input  logic                    lpreset,
  input  logic                    pl_linkUp,
  input  logic [3:0]              pl_state_sts,
  input  logic                    pl_trdy,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [31:0]             s_data,
  input  logic                    s_sop,
  input  logic                    s_eop,
  input  logic                    s_is_dlp,
  output logic                    lp_irdy,
  output logic [8*BEAT_BYTES-1:0] lp_data,
  output logic [BEAT_BYTES-1:0]   lp_valid,
  output logic [BEAT_BYTES-1:0]   lp_tlpstart,
  output logic [BEAT_BYTES-1:0]   lp_tlpend,
  output logic [BEAT_BYTES-1:0]   lp_dlpstart,
  output logic [BEAT_BYTES-1:0]   lp_dlpend,
  output logic                    pkt_dropped,
  output logic                    proto_err
`ifdef LPIF_TX_STATS_EN
  ,
  output logic [15:0]             tlp_sent_cnt,
  output logic [15:0]             dlp_sent_cnt
`endif
);

  localparam int DW_PER_BEAT = BEAT_BYTES / 4;

  lpif_tx_state_e state_q, state_d;
  lpif_beat_t     beat_q, beat_d;
  logic [4:0]     count_q, count_d;
  logic           in_pkt_q, in_pkt_d;
  logic           is_dlp_q, is_dlp_d;      // type latched at sop, used for eop
  logic           last_eop_q, last_eop_d;  // last written dword closed a packet
  logic           irdy_q, irdy_d;
  logic           drop_q, drop_d;
  logic           perr_q, perr_d;

  logic link_ok, acc, wr, xfer, cur_dlp;
  logic [LPIF_BYTES-1:0] m_valid, m_tlps, m_tlpe, m_dlps, m_dlpe;

  assign link_ok = pl_linkUp && (pl_state_sts == STS_ACTIVE);
  assign s_ready = link_ok && (state_q != SEND);
  assign acc     = s_valid && s_ready;
  // Non-sop dwords outside a packet are consumed but never written.
  assign wr      = acc && (s_sop || in_pkt_q);
  assign xfer    = irdy_q && pl_trdy;
  assign cur_dlp = s_sop ? s_is_dlp : is_dlp_q;

  lpif_tx_marker_gen u_marker_gen (
    .slot          (count_q[3:0]),
    .sop           (s_sop),
    .eop           (s_eop),
    .is_dlp        (cur_dlp),
    .valid_mask    (m_valid),
    .tlpstart_mask (m_tlps),
    .tlpend_mask   (m_tlpe),
    .dlpstart_mask (m_dlps),
    .dlpend_mask   (m_dlpe)
  );

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    count_d    = count_q;
    in_pkt_d   = in_pkt_q;
    is_dlp_d   = is_dlp_q;
    last_eop_d = last_eop_q;
    irdy_d     = irdy_q;
    drop_d     = 1'b0;
    perr_d     = acc && (s_sop ? in_pkt_q : !in_pkt_q);

    unique case (state_q)
      IDLE, FILL: begin
        if (state_q == FILL && !link_ok) begin
          state_d    = IDLE;
          beat_d     = '0;
          count_d    = '0;
          last_eop_d = 1'b0;
          in_pkt_d   = 1'b0;
          drop_d     = 1'b1;
        end else if (wr) begin
          beat_d.data[{count_q[3:0], 5'b0} +: 32] = s_data;
          beat_d.valid    = beat_q.valid    | m_valid;
          beat_d.tlpstart = beat_q.tlpstart | m_tlps;
          beat_d.tlpend   = beat_q.tlpend   | m_tlpe;
          beat_d.dlpstart = beat_q.dlpstart | m_dlps;
          beat_d.dlpend   = beat_q.dlpend   | m_dlpe;
          count_d    = count_q + 5'd1;
          in_pkt_d   = !s_eop;
          last_eop_d = s_eop;
          if (s_sop) is_dlp_d = s_is_dlp;
          if (count_q == 5'(DW_PER_BEAT - 1)) begin
            state_d = SEND;
            irdy_d  = 1'b1;
          end else begin
            state_d = FILL;
          end
        end else if (state_q == FILL && last_eop_q && !s_valid) begin
          // A packet just ended and nothing follows: ship the partial beat.
          state_d = SEND;
          irdy_d  = 1'b1;
        end
      end
      SEND: begin
        // A completing transfer wins over a same-cycle link loss.
        if (xfer || !link_ok) begin
          state_d    = IDLE;
          beat_d     = '0;
          count_d    = '0;
          last_eop_d = 1'b0;
          irdy_d     = 1'b0;
          if (!xfer) begin
            in_pkt_d = 1'b0;
            drop_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the beat buffer is reset like any other register because unused
  // slots must read back as zero data and zero markers.
  always_ff @(posedge LCLK or posedge lpreset) begin
    if (lpreset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      count_q    <= '0;
      in_pkt_q   <= 1'b0;
      is_dlp_q   <= 1'b0;
      last_eop_q <= 1'b0;
      irdy_q     <= 1'b0;
      drop_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      beat_q     <= beat_d;
      count_q    <= count_d;
      in_pkt_q   <= in_pkt_d;
      is_dlp_q   <= is_dlp_d;
      last_eop_q <= last_eop_d;
      irdy_q     <= irdy_d;
      drop_q     <= drop_d;
      perr_q     <= perr_d;
    end
  end

  assign lp_irdy     = irdy_q;
  assign lp_data     = beat_q.data;
  assign lp_valid    = beat_q.valid;
  assign lp_tlpstart = beat_q.tlpstart;
  assign lp_tlpend   = beat_q.tlpend;
  assign lp_dlpstart = beat_q.dlpstart;
  assign lp_dlpend   = beat_q.dlpend;
  assign pkt_dropped = drop_q;
  assign proto_err   = perr_q;

`ifdef LPIF_TX_STATS_EN
  logic [15:0] tlp_cnt_q, tlp_cnt_d, dlp_cnt_q, dlp_cnt_d;

  always_comb begin
    tlp_cnt_d = tlp_cnt_q;
    dlp_cnt_d = dlp_cnt_q;
    if (xfer) begin
      tlp_cnt_d = sat_add_cnt(tlp_cnt_q, beat_q.tlpend);
      dlp_cnt_d = sat_add_cnt(dlp_cnt_q, beat_q.dlpend);
    end
  end

  always_ff @(posedge LCLK or posedge lpreset) begin
    if (lpreset) begin
      tlp_cnt_q <= '0;
      dlp_cnt_q <= '0;
    end else begin
      tlp_cnt_q <= tlp_cnt_d;
      dlp_cnt_q <= dlp_cnt_d;
    end
  end

  assign tlp_sent_cnt = tlp_cnt_q;
  assign dlp_sent_cnt = dlp_cnt_q;
`endif

endmodule

// File: tb/tb_lpif_tx_packer.sv
// -----------------------------------------------------------------------------
// tb_lpif_tx_packer
// Directed bench for lpif_tx_packer (default build). Expected beats are built
// from the stimulus and queued; a negedge monitor pops and compares one entry
// per lp_irdy && pl_trdy transfer.
// -----------------------------------------------------------------------------
module tb_lpif_tx_packer;
  import lpif_pkg::*;

  logic         LCLK = 1'b0;
  logic         lpreset = 1'b1;
  logic         pl_linkUp = 1'b0;
  logic [3:0]   pl_state_sts = 4'h0;
  logic         pl_trdy = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_sop = 1'b0;
  logic         s_eop = 1'b0;
  logic         s_is_dlp = 1'b0;
  logic         lp_irdy;
  logic [511:0] lp_data;
  logic [63:0]  lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend;
  logic         pkt_dropped, proto_err;

  int n_checks = 0;
  int n_errors = 0;
  int irdy_hi  = 0;
  int n_xfer   = 0;
  int n_drop   = 0;
  int n_perr   = 0;

  lpif_beat_t sb[$];

  always #5 LCLK = ~LCLK;

  lpif_tx_packer dut (
    .LCLK         (LCLK),
    .lpreset      (lpreset),
    .pl_linkUp    (pl_linkUp),
    .pl_state_sts (pl_state_sts),
    .pl_trdy      (pl_trdy),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_sop        (s_sop),
    .s_eop        (s_eop),
    .s_is_dlp     (s_is_dlp),
    .lp_irdy      (lp_irdy),
    .lp_data      (lp_data),
    .lp_valid     (lp_valid),
    .lp_tlpstart  (lp_tlpstart),
    .lp_tlpend    (lp_tlpend),
    .lp_dlpstart  (lp_dlpstart),
    .lp_dlpend    (lp_dlpend),
    .pkt_dropped  (pkt_dropped),
    .proto_err    (proto_err)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic lpif_beat_t put_dw(input lpif_beat_t b, input int slot,
                                        input logic [31:0] d, input logic sop,
                                        input logic eop, input logic dlp);
    lpif_beat_t r;
    r = b;
    r.data[32*slot +: 32] = d;
    r.valid[4*slot +: 4]  = 4'hF;
    if (sop) begin
      if (dlp) r.dlpstart[4*slot] = 1'b1;
      else     r.tlpstart[4*slot] = 1'b1;
    end
    if (eop) begin
      if (dlp) r.dlpend[4*slot+3] = 1'b1;
      else     r.tlpend[4*slot+3] = 1'b1;
    end
    return r;
  endfunction

  // Monitor: counts events and scores every transferred beat.
  always @(negedge LCLK) begin
    lpif_beat_t e;
    if (!lpreset) begin
      if (lp_irdy)     irdy_hi++;
      if (pkt_dropped) n_drop++;
      if (proto_err)   n_perr++;
      if (lp_irdy && pl_trdy) begin
        n_xfer++;
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL xfer_unexpected: observed beat valid %0h expected no beat", lp_valid);
        end else begin
          e = sb.pop_front();
          check("xfer_data",     lp_data,     e.data);
          check("xfer_valid",    lp_valid,    e.valid);
          check("xfer_tlpstart", lp_tlpstart, e.tlpstart);
          check("xfer_tlpend",   lp_tlpend,   e.tlpend);
          check("xfer_dlpstart", lp_dlpstart, e.dlpstart);
          check("xfer_dlpend",   lp_dlpend,   e.dlpend);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t observed still running, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge LCLK);
    #1;
  endtask

  // Presents one dword and returns just after the edge that accepted it.
  task automatic send_dw(input logic [31:0] d, input logic sop, input logic eop, input logic dlp);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eop; s_is_dlp = dlp;
    @(negedge LCLK);
    while (!s_ready && n < 100) begin
      @(negedge LCLK);
      n++;
    end
    check("send_ready", s_ready, 1);
    tick();
  endtask

  task automatic idle();
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
  endtask

  task automatic wait_irdy();
    int n;
    n = 0;
    while (!lp_irdy && n < 50) begin
      tick();
      n++;
    end
    check("wait_irdy", lp_irdy, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    repeat (2) tick();
  endtask

  initial begin
    lpif_beat_t eb, eb2;
    int h0, x0, d0, p0;

    // Reset state
    repeat (3) tick();
    check("rst_irdy",  lp_irdy, 0);
    check("rst_valid", lp_valid, 0);
    check("rst_data",  lp_data, 0);
    check("rst_drop",  pkt_dropped, 0);
    check("rst_perr",  proto_err, 0);
    lpreset = 1'b0;
    tick();
    check("ready_link_down", s_ready, 0);
    pl_linkUp = 1'b1; pl_state_sts = 4'h2;
    #1 check("ready_not_active", s_ready, 0);
    pl_state_sts = STS_ACTIVE; pl_trdy = 1'b1;
    #1 check("ready_active", s_ready, 1);
    tick();

    // T1: single 3-dword TLP
    h0 = irdy_hi;
    eb = '0;
    for (int i = 0; i < 3; i++) eb = put_dw(eb, i, 32'h1000_0000 + 32'(i), i == 0, i == 2, 1'b0);
    sb.push_back(eb);
    for (int i = 0; i < 3; i++) send_dw(32'h1000_0000 + 32'(i), i == 0, i == 2, 1'b0);
    idle();
    wait_irdy();
    check("t1_valid",    lp_valid,    64'h0000_0000_0000_0FFF);
    check("t1_tlpstart", lp_tlpstart, 64'h1);
    check("t1_tlpend",   lp_tlpend,   64'h800);
    drain();
    check("t1_irdy_cycles", irdy_hi - h0, 1);

    // T2: 20-dword TLP spans two beats
    x0 = n_xfer;
    eb = '0; eb2 = '0;
    for (int i = 0; i < 16; i++) eb = put_dw(eb, i, 32'h2000_0000 + 32'(i), i == 0, 1'b0, 1'b0);
    for (int i = 16; i < 20; i++) eb2 = put_dw(eb2, i - 16, 32'h2000_0000 + 32'(i), 1'b0, i == 19, 1'b0);
    sb.push_back(eb);
    sb.push_back(eb2);
    for (int i = 0; i < 20; i++) send_dw(32'h2000_0000 + 32'(i), i == 0, i == 19, 1'b0);
    idle();
    drain();
    check("t2_xfers", n_xfer - x0, 2);
    check("t2_full_valid_const", eb.valid, {64{1'b1}});

    // T3: 1-dword DLP then 2-dword TLP in one beat
    eb = '0;
    eb = put_dw(eb, 0, 32'h3000_0000, 1'b1, 1'b1, 1'b1);
    eb = put_dw(eb, 1, 32'h3000_0001, 1'b1, 1'b0, 1'b0);
    eb = put_dw(eb, 2, 32'h3000_0002, 1'b0, 1'b1, 1'b0);
    sb.push_back(eb);
    send_dw(32'h3000_0000, 1'b1, 1'b1, 1'b1);
    send_dw(32'h3000_0001, 1'b1, 1'b0, 1'b0);
    send_dw(32'h3000_0002, 1'b0, 1'b1, 1'b0);
    idle();
    wait_irdy();
    check("t3_dlpstart", lp_dlpstart, 64'h1);
    check("t3_dlpend",   lp_dlpend,   64'h8);
    check("t3_tlpstart", lp_tlpstart, 64'h10);
    check("t3_tlpend",   lp_tlpend,   64'h800);
    drain();

    // T4: full beat held under backpressure
    pl_trdy = 1'b0;
    h0 = irdy_hi; x0 = n_xfer;
    eb = '0;
    for (int i = 0; i < 16; i++) eb = put_dw(eb, i, 32'h4000_0000 + 32'(i), i == 0, i == 15, 1'b0);
    sb.push_back(eb);
    for (int i = 0; i < 16; i++) send_dw(32'h4000_0000 + 32'(i), i == 0, i == 15, 1'b0);
    idle();
    wait_irdy();
    for (int c = 0; c < 6; c++) begin
      if (c == 5) pl_trdy = 1'b1;
      check("t4_irdy",  lp_irdy, 1);
      check("t4_data",  lp_data, eb.data);
      check("t4_ready", s_ready, 0);
      tick();
    end
    check("t4_irdy_after",  lp_irdy, 0);
    check("t4_irdy_cycles", irdy_hi - h0, 6);
    check("t4_xfers",       n_xfer - x0, 1);
    drain();

    // T5: link loss with 7 slots buffered
    d0 = n_drop; x0 = n_xfer; p0 = n_perr;
    for (int i = 0; i < 7; i++) send_dw(32'h5000_0000 + 32'(i), i == 0, 1'b0, 1'b0);
    idle();
    pl_linkUp = 1'b0;
    #1 check("t5_ready_down", s_ready, 0);
    tick();
    check("t5_drop_pulse", pkt_dropped, 1);
    check("t5_irdy",       lp_irdy, 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t5_ready_hold", s_ready, 0);
      check("t5_irdy_hold",  lp_irdy, 0);
    end
    check("t5_drop_count", n_drop - d0, 1);
    pl_linkUp = 1'b1;
    for (int i = 7; i < 10; i++) send_dw(32'h5000_0000 + 32'(i), 1'b0, i == 9, 1'b0);
    idle();
    repeat (5) tick();
    check("t5_perr_count", n_perr - p0, 3);
    check("t5_no_xfer",    n_xfer - x0, 0);
    check("t5_irdy_end",   lp_irdy, 0);

    // T6: sop in the middle of a packet
    p0 = n_perr;
    eb = '0;
    eb = put_dw(eb, 0, 32'h6000_0000, 1'b1, 1'b0, 1'b0);
    eb = put_dw(eb, 1, 32'h6000_0001, 1'b0, 1'b0, 1'b0);
    eb = put_dw(eb, 2, 32'h6000_0002, 1'b1, 1'b0, 1'b0);
    eb = put_dw(eb, 3, 32'h6000_0003, 1'b0, 1'b1, 1'b0);
    sb.push_back(eb);
    send_dw(32'h6000_0000, 1'b1, 1'b0, 1'b0);
    send_dw(32'h6000_0001, 1'b0, 1'b0, 1'b0);
    send_dw(32'h6000_0002, 1'b1, 1'b0, 1'b0);
    send_dw(32'h6000_0003, 1'b0, 1'b1, 1'b0);
    idle();
    wait_irdy();
    check("t6_tlpstart", lp_tlpstart, 64'h101);
    check("t6_tlpend",   lp_tlpend,   64'h8000);
    drain();
    check("t6_perr_count", n_perr - p0, 1);

    // T7: reset while a beat is presented
    pl_trdy = 1'b0;
    send_dw(32'h7000_0000, 1'b1, 1'b0, 1'b0);
    send_dw(32'h7000_0001, 1'b0, 1'b1, 1'b0);
    idle();
    wait_irdy();
    #2 lpreset = 1'b1;
    #1 check("t7_irdy_async", lp_irdy, 0);
    check("t7_valid_async", lp_valid, 0);
    tick();
    lpreset = 1'b0;
    repeat (3) tick();
    check("t7_irdy_after", lp_irdy, 0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lpif_tx_packer.md
Name: lpif_tx_packer

Overview:
- Link-layer-side LPIF transmitter.
- Accepts a dword-serial packet stream (TLPs and DLPs) from the link-layer packet source.
- Packs it into 512-bit LPIF beats with per-byte valid/start/end markers, then drives lp_irdy/lp_data toward the MAC under pl_trdy backpressure.
- Transmits only while the MAC reports link up and Active state.

Parameters:
- BEAT_BYTES, 64, bytes per LPIF beat; lp_data width = 8*BEAT_BYTES.
- DW_PER_BEAT, BEAT_BYTES/4 (=16), dword slots per beat; derived, not overridable.
- STS_ACTIVE, 4'h1, pl_state_sts encoding for the Active state.

Ports:
- LCLK  in  1  clock
- lpreset  in  1  async active-high reset
- pl_linkUp  in  1  MAC link-up
- pl_state_sts  in  4  MAC LPIF state
- pl_trdy  in  1  MAC ready for beat
- s_valid  in  1  input dword valid
- s_ready  out  1  input dword accepted when s_valid&&s_ready
- s_data  in  32  input dword; byte0 = bits[7:0]
- s_sop  in  1  first dword of packet
- s_eop  in  1  last dword of packet
- s_is_dlp  in  1  packet is DLP (sampled on sop)
- lp_irdy  out  1  beat valid
- lp_data  out  512  beat payload; slot k = bits[32k+31:32k]
- lp_valid  out  64  per-byte valid
- lp_tlpstart  out  64  per-byte TLP start marker
- lp_tlpend  out  64  per-byte TLP end marker
- lp_dlpstart  out  64  per-byte DLP start marker
- lp_dlpend  out  64  per-byte DLP end marker
- pkt_dropped  out  1  1-cycle pulse, buffered data discarded
- proto_err  out  1  1-cycle pulse, sop while in packet / non-sop dword while idle

Behaviour:
- Reset: every output and internal register = 0; state IDLE; slot count = 0; in_pkt = 0.
- link_ok = pl_linkUp && (pl_state_sts == STS_ACTIVE).
- States:
  - IDLE: buffer empty.
  - FILL: 1..15 slots used.
  - SEND: beat presented.
- s_ready = link_ok && state != SEND.
- One dword accepted per cycle into slot = count; count increments by 1.
- Markers for an accepted dword in slot k, all in the same beat:
  - lp_valid[4k+3:4k] = 4'hF.
  - On sop: set bit 4k of tlpstart or dlpstart, chosen by s_is_dlp.
  - On eop: set bit 4k+3 of tlpend or dlpend, using the type latched at sop.
  - A single-dword packet sets both its start and end bits.
- Packets may span beats; several packets may share one beat.
- FILL→SEND:
  - when count reaches 16 (same cycle as the 16th accept), or
  - when count>0, the last accepted dword had eop, and s_valid==0 this cycle.
- IDLE/FILL never flush mid-packet; partial beats wait indefinitely for more data.
- Output timing: lp_irdy rises the cycle after the transition. All lp_* outputs are registered and held stable while lp_irdy && !pl_trdy.
- Handshake: lp_irdy && pl_trdy = transfer.
  - Next cycle: lp_irdy=0, buffer cleared, state IDLE.
  - Minimum one cycle gap between beats; input is stalled during SEND.
- Unused slots in a beat: data 0, valid 0, markers 0.
- Link loss (link_ok falls) in FILL or SEND:
  - Buffer discarded; lp_irdy=0 next cycle; state IDLE; in_pkt cleared.
  - pkt_dropped pulses once.
  - The upstream remainder of a packet cut mid-way is discarded until the next sop; each discarded dword raises proto_err.
- proto_err cases:
  - sop while in_pkt: the new packet starts normally; the previous packet gets no end marker.
  - dword without sop while !in_pkt: dropped, s_ready still high.
- Simultaneous pl_trdy and link loss: the transfer completes, and no pkt_dropped.
- lpreset mid-beat: immediate clear; lp_irdy falls asynchronously.

Optional Feature:
- Macro LPIF_TX_STATS_EN.
- Defined: adds outputs tlp_sent_cnt[15:0] and dlp_sent_cnt[15:0].
  - Each increments by popcount of end markers in each transferred beat.
  - Counters saturate at 16'hFFFF and clear on lpreset.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package lpif_pkg holds:
  - LPIF_BYTES=64, LPIF_DW=16
  - STS_ACTIVE
  - typedef lpif_tx_state_e {IDLE, FILL, SEND}
  - typedef lpif_beat_t (struct of data/valid/4 marker vectors)
- One sub-module, lpif_tx_marker_gen: slot index + sop/eop/type → 64-bit marker/valid masks for one dword.

Test Plan:
- Single 3-dword TLP, pl_trdy=1, link Active → one beat:
  - lp_valid=64'h0000_0000_0000_0FFF
  - tlpstart bit0 set
  - tlpend bit11 set
  - lp_irdy for 1 cycle.
- 20-dword TLP → beat1 valid=all-ones, tlpstart bit0, no end; beat2 valid=64'hFFFF, tlpend bit15.
- 1-dword DLP then 2-dword TLP back-to-back → one beat:
  - dlpstart bit0, dlpend bit3
  - tlpstart bit4, tlpend bit11.
- Full beat, pl_trdy low 5 cycles → lp_irdy and lp_data stable 6 cycles; s_ready=0 throughout; single transfer.
- pl_linkUp drops with 7 slots buffered → pkt_dropped one pulse; lp_irdy stays 0; s_ready=0 until link_ok returns.
- sop asserted mid-packet → proto_err pulse; new start marker in next slot; no end marker for the truncated packet.
